// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               - if_state_t : fetch sequencer state (boot / run / halt)
//               - PC_INC     : byte distance between consecutive fetches
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } if_state_t;

  localparam int unsigned PC_INC = 4;

endpackage : if_pkg
`default_nettype wire

// File: rtl/if_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_gen
// Description : Fetch-address generator and IF-stage bookkeeping, placed in
//               front of a synchronous-read (1-cycle latency) instruction
//               memory. Produces the read address and flush every cycle and
//               tracks the PC/valid of the word currently on the memory
//               output. Applies stalls, EX redirects and halt.
// Ports       :
//   clk             in   clock
//   rst_n           in   synchronous active-low reset
//   stall           in   hold the IF stage
//   redirect        in   taken branch/jump from EX this cycle
//   redirect_target in   new fetch address
//   halt            in   stop fetching (exit only by reset)
//   mem_addr        out  read address to instruction memory
//   mem_flush       out  force next memory output to NOP
//   pc_if           out  address of the word on the memory output
//   pc_if_plus4     out  pc_if + 4 (link value)
//   if_valid        out  memory output is a real instruction
//   halted          out  fetch stopped
//   misaligned      out  sticky misaligned-redirect trap (MISALIGN_TRAP_EN only)
// Options     : MISALIGN_TRAP_EN - trap misaligned redirect targets instead
//               of silently word-aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_gen
  import if_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             halt,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_flush,
  output logic [WIDTH-1:0] pc_if,
  output logic [WIDTH-1:0] pc_if_plus4,
  output logic             if_valid,
  output logic             halted
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             misaligned
`endif
);

  localparam logic [WIDTH-1:0] C_INC = WIDTH'(PC_INC);

  if_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_if_q, pc_if_d;
  logic             if_valid_q, if_valid_d;

  logic [WIDTH-1:0] target_w;
  logic             trap_w;

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;

  assign target_w   = redirect_target;
  assign trap_w     = redirect && (redirect_target[1:0] != 2'b00);
  assign misaligned = misaligned_q;
`else
  // Low address bits are dropped: redirects always land on a word boundary.
  logic unused_tgt_lsb;

  assign target_w       = {redirect_target[WIDTH-1:2], 2'b00};
  assign trap_w         = 1'b0;
  assign unused_tgt_lsb = ^redirect_target[1:0];
`endif

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_if_d    = pc_if_q;
    if_valid_d = if_valid_q;
    mem_addr   = pc_q;
    mem_flush  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif

    case (state_q)
      S_HALT: begin
        // Frozen until reset; redirect and stall have no effect here.
        mem_flush = 1'b1;
      end

      default: begin
        if (trap_w) begin
          // Misaligned redirect is not taken; no read is issued this cycle.
          mem_flush  = 1'b1;
          if_valid_d = 1'b0;
          state_d    = S_HALT;
`ifdef MISALIGN_TRAP_EN
          misaligned_d = 1'b1;
`endif
        end else if (redirect) begin
          // The flush suppresses this cycle's read of the target, so the
          // target is re-fetched next cycle from pc (two bubbles total).
          mem_flush  = 1'b1;
          mem_addr   = target_w;
          pc_d       = target_w;
          pc_if_d    = target_w;
          if_valid_d = 1'b0;
          state_d    = S_RUN;
        end else if (halt) begin
          if_valid_d = 1'b0;
          state_d    = S_HALT;
        end else if (stall && (state_q == S_RUN)) begin
          // Re-read the held word so the memory output stays stable; if the
          // held word is a bubble, keep the memory producing a NOP.
          mem_addr  = pc_if_q;
          mem_flush = ~if_valid_q;
        end else begin
          pc_d       = pc_q + C_INC;
          pc_if_d    = pc_q;
          if_valid_d = 1'b1;
          state_d    = S_RUN;
        end
      end
    endcase

    if (!rst_n) begin
      mem_flush = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pc_if_q    <= RESET_PC;
      if_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_if_q    <= pc_if_d;
      if_valid_q <= if_valid_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign pc_if       = pc_if_q;
  assign pc_if_plus4 = pc_if_q + C_INC;
  assign if_valid    = if_valid_q;
  assign halted      = (state_q == S_HALT);

endmodule : if_pc_gen
`default_nettype wire

// File: tb/tb_if_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_pc_gen
// Description : Self-checking bench for if_pc_gen. A fetch-stream reference
//               model predicts, per cycle, the address presented to memory,
//               the flush, and which fetched word is valid on the memory
//               output one cycle later. A second instance with a high
//               RESET_PC exercises address wrap-around.
// Options     : MISALIGN_TRAP_EN - also checks the misaligned trap output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic [31:0] mem_addr;
  logic        mem_flush;
  logic [31:0] pc_if;
  logic [31:0] pc_if_plus4;
  logic        if_valid;
  logic        halted;

  logic [31:0] w_mem_addr;
  logic        w_mem_flush;
  logic [31:0] w_pc_if;
  logic [31:0] w_pc_if_plus4;
  logic        w_if_valid;
  logic        w_halted;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic w_misaligned;
`endif

  always #5 clk = ~clk;

  if_pc_gen #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .mem_addr        (mem_addr),
    .mem_flush       (mem_flush),
    .pc_if           (pc_if),
    .pc_if_plus4     (pc_if_plus4),
    .if_valid        (if_valid),
    .halted          (halted)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned      (misaligned)
`endif
  );

  if_pc_gen #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (1'b0),
    .redirect        (1'b0),
    .redirect_target (32'h0),
    .halt            (1'b0),
    .mem_addr        (w_mem_addr),
    .mem_flush       (w_mem_flush),
    .pc_if           (w_pc_if),
    .pc_if_plus4     (w_pc_if_plus4),
    .if_valid        (w_if_valid),
    .halted          (w_halted)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned      (w_misaligned)
`endif
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: fetch-stream view of the IF stage.
  logic [31:0] m_next;   // next sequential fetch address
  logic [31:0] m_last;   // address presented by the last issued read
  logic        m_valid;  // word now on the memory output is real
  logic        m_halted;
  logic        m_boot;
  logic        m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_next   = 32'h0;
    m_last   = 32'h0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_boot   = 1'b1;
    m_mis    = 1'b0;
  endtask

  // Called at the negedge; reset overrides whatever else is applied.
  task automatic do_reset();
    rst_n           = 1'b0;
    stall           = 1'($urandom_range(0, 1));
    redirect        = 1'($urandom_range(0, 1));
    redirect_target = $urandom;
    halt            = 1'($urandom_range(0, 1));
    #1;
    chk("flush_in_reset", {31'b0, mem_flush}, 32'd1);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    #1;
    chk("if_valid_after_reset", {31'b0, if_valid}, 32'd0);
    chk("halted_after_reset", {31'b0, halted}, 32'd0);
  endtask

  // One clock cycle of stimulus, called at the negedge.
  task automatic step(input logic s, input logic r, input logic [31:0] t, input logic h);
    logic [31:0] e_addr;
    logic [31:0] tgt;
    logic        e_flush;
    logic        addr_known;
    logic        trap;

    stall           = s;
    redirect        = r;
    redirect_target = t;
    halt            = h;
    #1;

    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
    if (m_valid) begin
      chk("pc_if", pc_if, m_last);
      chk("pc_if_plus4", pc_if_plus4, m_last + 32'd4);
    end
`ifdef MISALIGN_TRAP_EN
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    tgt  = t;
    trap = r && (t[1:0] != 2'b00);
`else
    tgt  = t & 32'hFFFF_FFFC;
    trap = 1'b0;
`endif

    e_addr     = m_next;
    e_flush    = 1'b0;
    addr_known = 1'b1;

    if (m_halted) begin
      e_flush    = 1'b1;
      addr_known = 1'b0;
    end else if (trap) begin
      e_flush = 1'b1;
    end else if (r) begin
      e_addr  = tgt;
      e_flush = 1'b1;
    end else if (h) begin
      e_flush = 1'b0;
    end else if (s && !m_boot) begin
      e_addr  = m_last;
      e_flush = !m_valid;
    end

    chk("mem_flush", {31'b0, mem_flush}, {31'b0, e_flush});
    if (addr_known) begin
      chk("mem_addr", mem_addr, e_addr);
    end

    @(posedge clk);
    if (m_halted) begin
      // nothing moves
    end else if (trap) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
      m_mis    = 1'b1;
    end else if (r) begin
      // flushed read of the target: the target is fetched again next cycle
      m_last  = tgt;
      m_next  = tgt;
      m_valid = 1'b0;
      m_boot  = 1'b0;
    end else if (h) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (s && !m_boot) begin
      // word held; nothing advances
    end else begin
      m_last  = m_next;
      m_next  = m_next + 32'd4;
      m_valid = 1'b1;
      m_boot  = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] t;
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    halt            = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset release and straight-line fetch; wrap instance checked alongside.
    do_reset();
    chk("wrap_addr0", w_mem_addr, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr1", w_mem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr2", w_mem_addr, 32'h0000_0000);
    chk("wrap_pc_if", w_pc_if, 32'hFFFF_FFFC);
    chk("wrap_plus4", w_pc_if_plus4, 32'h0000_0000);
    chk("wrap_valid", {31'b0, w_if_valid}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Three-cycle stall while pc_if=8 is valid, then resume at 12.
    chk("pc_if_before_stall", pc_if, 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect to 0x40 while fetching 0x10.
    chk("pc_before_redirect", mem_addr, 32'h10);
    step(1'b0, 1'b1, 32'h40, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Stall and redirect together: redirect wins.
    step(1'b1, 1'b1, 32'h80, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Misaligned redirect target: aligned in the default build, trapped otherwise.
    step(1'b0, 1'b1, 32'h42, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Halt, then redirect and stall are ignored until reset.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        do_reset();
      end else begin
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF4 + 32'($urandom_range(0, 2)) * 32'd4;
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        step(1'($urandom_range(0, 99) < 25),
             1'($urandom_range(0, 99) < 12),
             t,
             1'($urandom_range(0, 199) < 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_if_pc_gen
`default_nettype wire

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- Fetch-address generator and IF-stage bookkeeping. Sits directly upstream of the synchronous-read instruction memory.
- Drives the memory read address and flush every cycle.
- Tracks the PC of the instruction currently on the memory output and qualifies it with a valid bit for the IF/ID register.
- Applies hazard-unit stalls, EX-stage branch/jump redirects and halt.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- stall  in  1  hazard unit: hold the IF stage
- redirect  in  1  EX: taken branch/jump this cycle
- redirect_target  in  WIDTH  EX: new fetch address
- halt  in  1  ecall/ebreak retired: stop fetching
- mem_addr  out  WIDTH  read address to instruction memory pc port
- mem_flush  out  1  flush to instruction memory (next instr_out = NOP)
- pc_if  out  WIDTH  address of the word on instr_out this cycle
- pc_if_plus4  out  WIDTH  pc_if+4, for JAL/JALR link
- if_valid  out  1  instr_out is a real instruction
- halted  out  1  fetch stopped

Behaviour:
- Registers: pc (next fetch address), pc_if, if_valid, state {S_BOOT, S_RUN, S_HALT}.
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC, pc_if=RESET_PC, if_valid=0, state=S_BOOT, halted=0.
  - mem_flush=1 combinationally while rst_n=0, so memory outputs NOP.
- Memory latency is 1 cycle. The address presented in cycle N appears on instr_out in N+1; pc_if/if_valid are registered to align with it.
- S_BOOT (first cycle after reset release):
  - mem_addr=pc, if_valid=0.
  - At the edge: pc<=pc+4, pc_if<=pc, if_valid<=1, state<=S_RUN.
- S_RUN, no events: mem_addr=pc; pc<=pc+4; pc_if<=pc; if_valid<=1.
- Stall (S_RUN, stall=1, redirect=0):
  - pc, pc_if and if_valid hold.
  - mem_addr=pc_if, so the memory re-reads the held word and instr_out stays stable.
  - If if_valid=0, mem_flush=1 so the NOP is held.
- Redirect (any state but S_HALT; priority over stall and halt):
  - mem_flush=1, mem_addr=redirect_target.
  - At the edge: pc<=redirect_target+4, pc_if<=redirect_target, if_valid<=1.
  - Result: instr_out is flushed to NOP for one cycle, then mem[target] appears with if_valid=1.
  - Correction: the memory flush overrides that read. Therefore pc<=redirect_target, pc_if<=redirect_target, if_valid<=0, and the target is fetched in the following cycle. This is the normative behaviour; penalty is 2 bubbles.
- Halt (redirect=0):
  - state<=S_HALT, if_valid<=0.
  - In S_HALT: mem_flush=1, pc and pc_if frozen, halted=1.
  - Exit only by reset. Redirect and stall are ignored in S_HALT.
- Arithmetic: pc+4 and pc_if+4 wrap modulo 2^WIDTH; 32'hFFFF_FFFC+4 = 0. No carry out.
- Simultaneous stall+redirect → redirect wins. Simultaneous halt+redirect → redirect wins; halt is re-asserted by the pipeline if still valid.
- Reset mid-stall or mid-redirect: reset overrides everything.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_target[1:0]!=0 is not taken.
  - Extra output misaligned (1b, reset 0) is set and sticky.
  - State goes to S_HALT.
- Undefined:
  - redirect_target[1:0] is forced to 0 and no trap is raised.
  - Port misaligned is absent.

Decomposition:
- Shared package if_pkg:
  - typedef enum logic [1:0] if_state_t {S_BOOT, S_RUN, S_HALT}
  - localparam PC_INC=4
- RESET_PC stays a module parameter. Continue using REG_RANGE and NOP from inst_defs.
- No sub-module is needed. Optional: pc_next_mux as a small combinational helper, not required.

Test Plan:
- Reset release with RESET_PC=0, no events:
  - mem_addr = 0, 4, 8, 12 on successive cycles.
  - if_valid=0 in the first cycle, then pc_if = 0, 4, 8 with if_valid=1.
- Stall for 3 cycles while pc_if=8 is valid:
  - mem_addr=8 throughout; pc_if=8, if_valid=1 held.
  - Fetch resumes at 12.
- Redirect to 0x40 at pc=0x10:
  - mem_flush=1 that cycle, then if_valid=0.
  - Next: mem_addr=0x40; following cycle pc_if=0x40, if_valid=1.
- Stall and redirect to 0x80 in the same cycle: redirect taken, stall ignored. Halt asserted: halted=1, mem_flush=1 permanently, if_valid=0; redirect then ignored; rst_n=0 clears it.
- RESET_PC=32'hFFFF_FFF8: pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- MISALIGN_TRAP_EN defined, redirect_target=0x42: misaligned=1, halted=1, no fetch from 0x42. Undefined: fetch proceeds at 0x40.
